// File: rtl/store_fifo_pkg.sv
// Shared defaults, status-bit layout and width helpers for the store output FIFO.
package store_fifo_pkg;

    localparam int DW_D    = 4;
    localparam int AW_D    = 4;
    localparam int DEPTH_D = 8;

    localparam logic [3:0] PORT_ADDR_D = 4'hF;
    localparam logic [3:0] STAT_ADDR_D = 4'hE;

    localparam int ST_OVF   = 3;
    localparam int ST_FULL  = 2;
    localparam int ST_EMPTY = 1;
    localparam int ST_LOW   = 0;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef logic [ptr_w(DEPTH_D)-1:0] ptr_t;
    typedef logic [ptr_w(DEPTH_D):0]   count_t;

endpackage

// File: rtl/store_output_fifo_sfifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port.
module sfifo_ram
    import store_fifo_pkg::*;
#(
    parameter int DW    = DW_D,
    parameter int DEPTH = DEPTH_D
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
    input  logic [DW-1:0]             i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
    output logic [DW-1:0]             o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Storage write; contents are intentionally left uninitialised by reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/store_output_fifo.sv
// Snooping store-port FIFO with valid/ready drain and status word.
// Optional macro STORE_FIFO_COUNT_EN adds the LEVEL port and the low-water status bit.
module store_output_fifo
    import store_fifo_pkg::*;
#(
    parameter int            DW        = DW_D,
    parameter int            AW        = AW_D,
    parameter int            DEPTH     = DEPTH_D,
    parameter logic [AW-1:0] PORT_ADDR = PORT_ADDR_D,
    parameter logic [AW-1:0] STAT_ADDR = STAT_ADDR_D
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    MW,
    input  logic [AW-1:0]           ADDR,
    input  logic [DW-1:0]           WDATA,
    output logic                    RD_HIT,
    output logic [DW-1:0]           RD_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [DW-1:0]           OUT_DATA,
`ifdef STORE_FIFO_COUNT_EN
    output logic [ptr_w(DEPTH):0]   LEVEL,
`endif
    output logic                    OVF
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];
    localparam logic [PW:0]   CNT_HALF = (DEPTH / 2);
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE  = 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_clr;
    logic [PW:0]   w_count_nxt;
    logic          w_ovf_nxt;
    logic [DW-1:0] w_ram_rdata;
    logic [DW-1:0] w_status;

    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push_req = MW && (ADDR == PORT_ADDR);
    assign w_pop      = OUT_VALID && OUT_READY;
    // A full FIFO still accepts a store when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_clr      = MW && (ADDR == STAT_ADDR) && WDATA[DW-1];

    // Occupancy and overflow next-state; a drop outranks a clear.
    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
        if (w_drop) begin
            w_ovf_nxt = 1'b1;
        end else if (w_clr) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf;
        end
    end

    // Pointer, count and overflow state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    sfifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (WDATA),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    // Status word assembly.
    always_comb begin
        w_status           = '0;
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
`ifdef STORE_FIFO_COUNT_EN
        w_status[ST_LOW]   = !w_empty && (r_count < CNT_HALF);
`else
        w_status[ST_LOW]   = 1'b0;
`endif
    end

    assign RD_HIT    = (ADDR == STAT_ADDR);
    assign RD_DATA   = w_status;
    assign OVF       = r_ovf;
    assign OUT_VALID = !w_empty;
    // Mask the unreset RAM so the output reads zero while empty.
    assign OUT_DATA  = OUT_VALID ? w_ram_rdata : '0;
`ifdef STORE_FIFO_COUNT_EN
    assign LEVEL     = r_count;
`endif

endmodule

// File: tb/tb_store_output_fifo.sv
// Directed self-checking bench for store_output_fifo (default configuration).
module tb_store_output_fifo;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       MW;
    logic [3:0] ADDR;
    logic [3:0] WDATA;
    logic       RD_HIT;
    logic [3:0] RD_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [3:0] OUT_DATA;
    logic       OVF;
`ifdef STORE_FIFO_COUNT_EN
    logic [3:0] LEVEL;
`endif

    int checks   = 0;
    int failures = 0;

    store_output_fifo dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .MW        (MW),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .RD_HIT    (RD_HIT),
        .RD_DATA   (RD_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
`ifdef STORE_FIFO_COUNT_EN
        .LEVEL     (LEVEL),
`endif
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [3:0] a, input logic [3:0] d);
        MW    = 1'b1;
        ADDR  = a;
        WDATA = d;
        tick();
        MW    = 1'b0;
        ADDR  = 4'h0;
        WDATA = 4'h0;
    endtask

    task automatic status(input string tag, input logic [3:0] exp);
        ADDR = 4'hE;
        #1;
        chk({tag, "_hit"}, {7'd0, RD_HIT}, 8'd1);
        chk(tag, {4'd0, RD_DATA}, {4'd0, exp});
        ADDR = 4'h0;
    endtask

    initial begin
        logic [3:0] exp_q [8];

        // 1: reset
        RST_N = 1'b0; MW = 1'b0; ADDR = 4'hE; WDATA = 4'h0; OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        #1;
        chk("rst_valid", {7'd0, OUT_VALID}, 8'd0);
        chk("rst_ovf",   {7'd0, OVF},       8'd0);
        chk("rst_data",  {4'd0, OUT_DATA},  8'd0);
        status("rst_status", 4'b0010);

        // 2: two stores, then drain
        store(4'hF, 4'h5);
        chk("t2_valid1", {7'd0, OUT_VALID}, 8'd1);
        chk("t2_data1",  {4'd0, OUT_DATA},  8'h05);
        store(4'hF, 4'hA);
        chk("t2_hold",   {4'd0, OUT_DATA},  8'h05);
        OUT_READY = 1'b1;
        tick();
        chk("t2_data2",  {4'd0, OUT_DATA},  8'h0A);
        tick();
        chk("t2_empty",  {7'd0, OUT_VALID}, 8'd0);
        OUT_READY = 1'b0;

        // 3: overflow on the ninth store, then drain in order
        for (int i = 1; i <= 8; i++) store(4'hF, 4'(i));
        status("t3_full", 4'b0100);
        store(4'hF, 4'h9);
        chk("t3_ovf", {7'd0, OVF}, 8'd1);
        status("t3_full_ovf", 4'b1100);
        OUT_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("t3_drain", {4'd0, OUT_DATA}, 8'(i));
            tick();
        end
        chk("t3_empty", {7'd0, OUT_VALID}, 8'd0);
        OUT_READY = 1'b0;

        // 4: store into a full FIFO while popping
        for (int i = 1; i <= 8; i++) store(4'hF, 4'(i));
        OUT_READY = 1'b1;
        store(4'hF, 4'hC);
        OUT_READY = 1'b0;
        status("t4_full_kept", 4'b1100);
        chk("t4_head", {4'd0, OUT_DATA}, 8'h02);

        // 5: overflow clear rules
        store(4'hE, 4'h7);
        chk("t5_noclr", {7'd0, OVF}, 8'd1);
        store(4'hE, 4'h8);
        chk("t5_clr", {7'd0, OVF}, 8'd0);
        status("t5_status", 4'b0100);
        store(4'hF, 4'hD);
        chk("t5_reset", {7'd0, OVF}, 8'd1);
        exp_q = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC};
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t5_drain", {4'd0, OUT_DATA}, {4'd0, exp_q[i]});
            tick();
        end
        OUT_READY = 1'b0;

        // 6: reset in the middle of a drain
        for (int i = 1; i <= 5; i++) store(4'hF, 4'(i));
        OUT_READY = 1'b1;
        tick();
        chk("t6_mid", {4'd0, OUT_DATA}, 8'h02);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_rst_valid", {7'd0, OUT_VALID}, 8'd0);
        chk("t6_rst_data",  {4'd0, OUT_DATA},  8'd0);
        chk("t6_rst_ovf",   {7'd0, OVF},       8'd0);
        OUT_READY = 1'b0;
        tick();
        RST_N = 1'b1;
        #1;
        status("t6_empty", 4'b0010);
        store(4'hF, 4'h3);
        chk("t6_valid", {7'd0, OUT_VALID}, 8'd1);
        chk("t6_first", {4'd0, OUT_DATA},  8'h03);
        status("t6_status", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
